// File: rtl/dest_fwd_if.sv
// Bundle for the destination-register pipeline: EX/ID inputs plus the
// pipelined destinations and forwarding/stall decisions returned to the core.
interface dest_fwd_if #(parameter int AW = 5);
    logic          hold;
    logic [AW-1:0] ex_wreg;
    logic          ex_regwrite;
    logic          ex_memread;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          load_use_stall;
    logic [AW-1:0] mem_wreg;
    logic          mem_regwrite;
    logic [AW-1:0] wb_wreg;
    logic          wb_regwrite;

    modport master (
        output hold, ex_wreg, ex_regwrite, ex_memread, ex_rs, ex_rt, id_rs, id_rt,
        input  fwd_a, fwd_b, load_use_stall, mem_wreg, mem_regwrite, wb_wreg, wb_regwrite
    );

    modport slave (
        input  hold, ex_wreg, ex_regwrite, ex_memread, ex_rs, ex_rt, id_rs, id_rt,
        output fwd_a, fwd_b, load_use_stall, mem_wreg, mem_regwrite, wb_wreg, wb_regwrite
    );
endinterface

// File: rtl/dest_fwd_pipe.sv
// Carries the EX write-register through EX/MEM and MEM/WB and derives operand
// forwarding selects and the load-use stall. WB_BYPASS_EN adds a WB/END stage (select 11).
module dest_fwd_pipe (
    input  logic       clk,
    input  logic       reset,
    dest_fwd_if.slave  bus
);
    localparam int AW = $bits(bus.ex_wreg);

    logic [AW-1:0] mem_wreg_r;
    logic          mem_regwrite_r;
    logic          mem_memread_r;
    logic [AW-1:0] wb_wreg_r;
    logic          wb_regwrite_r;
    logic [AW-1:0] end_wreg_s;
    logic          end_regwrite_s;
    logic [1:0]    fwd_a_s;
    logic [1:0]    fwd_b_s;
    logic          load_use_stall_s;

    // Register 0 is hardwired zero, so a write to it is never a real producer.
    function automatic logic hit(input logic we, input logic [AW-1:0] dst,
                                 input logic [AW-1:0] src);
        return we && (dst != {AW{1'b0}}) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        logic [1:0] sel;
        if (hit(mem_regwrite_r, mem_wreg_r, src)) begin
            sel = 2'b10;
        end else if (hit(wb_regwrite_r, wb_wreg_r, src)) begin
            sel = 2'b01;
        end else if (hit(end_regwrite_s, end_wreg_s, src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // EX/MEM and MEM/WB stage registers, frozen by hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wreg_r     <= {AW{1'b0}};
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            wb_wreg_r      <= {AW{1'b0}};
            wb_regwrite_r  <= 1'b0;
        end else if (!bus.hold) begin
            mem_wreg_r     <= bus.ex_wreg;
            mem_regwrite_r <= bus.ex_regwrite;
            mem_memread_r  <= bus.ex_memread;
            wb_wreg_r      <= mem_wreg_r;
            wb_regwrite_r  <= mem_regwrite_r;
        end else begin
            mem_wreg_r     <= mem_wreg_r;
            mem_regwrite_r <= mem_regwrite_r;
            mem_memread_r  <= mem_memread_r;
            wb_wreg_r      <= wb_wreg_r;
            wb_regwrite_r  <= wb_regwrite_r;
        end
    end

`ifdef WB_BYPASS_EN
    logic [AW-1:0] end_wreg_r;
    logic          end_regwrite_r;

    // WB/END stage: covers a register file that does not write before read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            end_wreg_r     <= {AW{1'b0}};
            end_regwrite_r <= 1'b0;
        end else if (!bus.hold) begin
            end_wreg_r     <= wb_wreg_r;
            end_regwrite_r <= wb_regwrite_r;
        end else begin
            end_wreg_r     <= end_wreg_r;
            end_regwrite_r <= end_regwrite_r;
        end
    end

    assign end_wreg_s     = end_wreg_r;
    assign end_regwrite_s = end_regwrite_r;
`else
    assign end_wreg_s     = {AW{1'b0}};
    assign end_regwrite_s = 1'b0;
`endif

    // Forwarding selects and load-use detection track current inputs with zero latency.
    always_comb begin
        fwd_a_s          = fwd_sel(bus.ex_rs);
        fwd_b_s          = fwd_sel(bus.ex_rt);
        load_use_stall_s = 1'b0;
        if (bus.ex_memread && (hit(bus.ex_regwrite, bus.ex_wreg, bus.id_rs) ||
                               hit(bus.ex_regwrite, bus.ex_wreg, bus.id_rt))) begin
            load_use_stall_s = 1'b1;
        end else begin
            load_use_stall_s = 1'b0;
        end
    end

    assign bus.fwd_a          = fwd_a_s;
    assign bus.fwd_b          = fwd_b_s;
    assign bus.load_use_stall = load_use_stall_s;
    assign bus.mem_wreg       = mem_wreg_r;
    assign bus.mem_regwrite   = mem_regwrite_r;
    assign bus.wb_wreg        = wb_wreg_r;
    assign bus.wb_regwrite    = wb_regwrite_r;
endmodule

// File: tb/tb_dest_fwd_pipe.sv
// Directed bench for dest_fwd_pipe: reset, forwarding priority, zero register,
// load-use, hold and hold-with-reset; WB_BYPASS_EN enables the select-11 checks.
module tb_dest_fwd_pipe;
    logic clk;
    logic reset;
    int   checks_r;
    int   errors_r;

    dest_fwd_if #(.AW(5)) bus ();

    dest_fwd_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wreg, input logic rw, input logic mr);
        bus.ex_wreg     = wreg;
        bus.ex_regwrite = rw;
        bus.ex_memread  = mr;
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset = 1'b1;
        bus.hold = 1'b0;
        set_ex(5'd0, 1'b0, 1'b0);
        bus.ex_rs = 5'd0; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #3;
        check("rst_mem_rw", {7'd0, bus.mem_regwrite}, 8'd0);
        check("rst_wb_rw",  {7'd0, bus.wb_regwrite},  8'd0);
        check("rst_fwd_a",  {6'd0, bus.fwd_a},        8'd0);
        check("rst_stall",  {7'd0, bus.load_use_stall}, 8'd0);
        step();
        reset = 1'b0;

        // EX/MEM then MEM/WB forward of reg 8
        set_ex(5'd8, 1'b1, 1'b0);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        bus.ex_rs = 5'd8; bus.ex_rt = 5'd3;
        #1;
        check("exmem_wreg", {3'd0, bus.mem_wreg}, 8'd8);
        check("exmem_rw",   {7'd0, bus.mem_regwrite}, 8'd1);
        check("exmem_fa",   {6'd0, bus.fwd_a}, 8'h2);
        check("exmem_fb",   {6'd0, bus.fwd_b}, 8'h0);
        step();
        check("memwb_wreg", {3'd0, bus.wb_wreg}, 8'd8);
        check("memwb_fa",   {6'd0, bus.fwd_a}, 8'h1);

        // priority: back-to-back writes of reg 9
        set_ex(5'd9, 1'b1, 1'b0);
        step();
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        bus.ex_rs = 5'd0; bus.ex_rt = 5'd9;
        #1;
        check("prio_fb_10", {6'd0, bus.fwd_b}, 8'h2);
        check("prio_fa_00", {6'd0, bus.fwd_a}, 8'h0);
        step();
        check("prio_fb_01", {6'd0, bus.fwd_b}, 8'h1);

        // zero register never forwards or stalls
        set_ex(5'd0, 1'b1, 1'b1);
        bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        check("zero_stall", {7'd0, bus.load_use_stall}, 8'd0);
        step();
        check("zero_fa_mem", {6'd0, bus.fwd_a}, 8'h0);
        check("zero_stall2", {7'd0, bus.load_use_stall}, 8'd0);
        step();
        check("zero_fa_wb", {6'd0, bus.fwd_a}, 8'h0);
        check("zero_wb_rw", {7'd0, bus.wb_regwrite}, 8'd1);

        // load-use
        set_ex(5'd5, 1'b1, 1'b1);
        bus.id_rs = 5'd0; bus.id_rt = 5'd5;
        #1;
        check("lu_rt", {7'd0, bus.load_use_stall}, 8'd1);
        bus.id_rs = 5'd5; bus.id_rt = 5'd1;
        #1;
        check("lu_rs", {7'd0, bus.load_use_stall}, 8'd1);
        bus.id_rs = 5'd6; bus.id_rt = 5'd6;
        #1;
        check("lu_miss", {7'd0, bus.load_use_stall}, 8'd0);
        bus.id_rt = 5'd5; bus.ex_memread = 1'b0;
        #1;
        check("lu_noload", {7'd0, bus.load_use_stall}, 8'd0);

        // hold freezes all stages
        set_ex(5'd12, 1'b1, 1'b0);
        step();
        bus.hold = 1'b1;
        set_ex(5'd0, 1'b0, 1'b0);
        bus.ex_rs = 5'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_mem_wreg", {3'd0, bus.mem_wreg}, 8'd12);
            check("hold_fa",       {6'd0, bus.fwd_a}, 8'h2);
            check("hold_wb_wreg",  {3'd0, bus.wb_wreg}, 8'd0);
            check("hold_wb_rw",    {7'd0, bus.wb_regwrite}, 8'd1);
        end
        bus.hold = 1'b0;
        step();
        check("unhold_wb_wreg", {3'd0, bus.wb_wreg}, 8'd12);
        check("unhold_mem_rw",  {7'd0, bus.mem_regwrite}, 8'd0);
        check("unhold_fa",      {6'd0, bus.fwd_a}, 8'h1);
        step();
`ifdef WB_BYPASS_EN
        check("end_fa", {6'd0, bus.fwd_a}, 8'h3);
`else
        check("end_fa", {6'd0, bus.fwd_a}, 8'h0);
`endif
        step();
        check("drain_fa", {6'd0, bus.fwd_a}, 8'h0);

        // async reset mid-cycle, coinciding with hold
        set_ex(5'd7, 1'b1, 1'b0);
        step();
        set_ex(5'd7, 1'b1, 1'b0);
        step();
        bus.hold = 1'b1;
        bus.ex_rs = 5'd7; bus.ex_rt = 5'd7;
        #1;
        check("pre_rst_rw", {7'd0, bus.mem_regwrite}, 8'd1);
        check("pre_rst_fa", {6'd0, bus.fwd_a}, 8'h2);
        #1;
        reset = 1'b1;
        #1;
        check("arst_mem_rw", {7'd0, bus.mem_regwrite}, 8'd0);
        check("arst_wb_rw",  {7'd0, bus.wb_regwrite}, 8'd0);
        check("arst_mem_wreg", {3'd0, bus.mem_wreg}, 8'd0);
        check("arst_fa", {6'd0, bus.fwd_a}, 8'h0);
        check("arst_fb", {6'd0, bus.fwd_b}, 8'h0);
        step();
        reset = 1'b0;
        bus.hold = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end
endmodule
